// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bus: serial bit stream in, assembled word out with a
// valid/ready handshake plus status.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             din;
  logic             din_valid;
  logic             flush;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    bit_count;
  logic             overflow;

  modport master (
    output din, din_valid, flush, dout_ready,
    input  dout, dout_valid, bit_count, overflow
  );

  modport slave (
    input  din, din_valid, flush, dout_ready,
    output dout, dout_valid, bit_count, overflow
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: shifts qualified bits into a WIDTH-bit register
// and hands each completed word to a one-deep output register.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  sipo_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_p0;
  logic [CW-1:0]    count_p0;
  logic [WIDTH-1:0] dout_p1;
  logic             vld_p1;
  logic             overflow_p1;

  logic [WIDTH-1:0] word_next;
  logic             consume;
  logic             complete;
  logic             handshake;
  logic             load;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  // A flush swallows any bit presented on the same edge.
  assign consume   = bus.din_valid && !bus.flush;
  assign word_next = shift_in(shift_p0, bus.din);
  assign complete  = consume && (count_p0 == CW'(WIDTH - 1));
  assign handshake = vld_p1 && bus.dout_ready;
  assign load      = complete && (!vld_p1 || bus.dout_ready);

  // Stage 0: serial shift register and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_p0 <= '0;
      count_p0 <= '0;
    end else if (bus.flush) begin
      shift_p0 <= '0;
      count_p0 <= '0;
    end else if (bus.din_valid) begin
      shift_p0 <= word_next;
      count_p0 <= complete ? '0 : count_p0 + CW'(1);
    end
  end

  // Stage 1: output holding register; a word arriving into a full, stalled register is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_p1     <= '0;
      vld_p1      <= 1'b0;
      overflow_p1 <= 1'b0;
    end else begin
      if (load) begin
        dout_p1 <= word_next;
        vld_p1  <= 1'b1;
      end else if (handshake) begin
        vld_p1  <= 1'b0;
      end
      if (complete && vld_p1 && !bus.dout_ready)
        overflow_p1 <= 1'b1;
    end
  end

  assign bus.dout       = dout_p1;
  assign bus.dout_valid = vld_p1;
  assign bus.bit_count  = count_p0;
  assign bus.overflow   = overflow_p1;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus
// stream and are compared every cycle against a bit-queue reference model.
module tb_sipo_deserializer;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic flush = 1'b0;
  logic dout_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  bit         q[$];
  logic [W-1:0] exp_m = '0;
  logic [W-1:0] exp_l = '0;
  logic       exp_v = 1'b0;
  logic       exp_o = 1'b0;

  sipo_deserializer_if #(.WIDTH(W)) bus_m ();
  sipo_deserializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.din = din;
  assign bus_m.din_valid = din_valid;
  assign bus_m.flush = flush;
  assign bus_m.dout_ready = dout_ready;
  assign bus_l.din = din;
  assign bus_l.din_valid = din_valid;
  assign bus_l.flush = flush;
  assign bus_l.dout_ready = dout_ready;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .bus(bus_m.slave)
  );
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .bus(bus_l.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word value from a completed bit list: first bit has weight 2^(W-1) or 2^0.
  task automatic model_edge(input logic r, input logic d, input logic dv, input logic fl,
                            input logic rdy);
    logic         done;
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    done = 1'b0;
    wm = '0;
    wl = '0;
    if (r) begin
      q.delete();
      exp_m = '0; exp_l = '0; exp_v = 1'b0; exp_o = 1'b0;
    end else begin
      if (fl) q.delete();
      else if (dv) begin
        q.push_back(d);
        if (q.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm = wm | (W'(q[i]) << (W - 1 - i));
            wl = wl | (W'(q[i]) << i);
          end
          q.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!exp_v || rdy) begin
          exp_m = wm; exp_l = wl; exp_v = 1'b1;
        end else begin
          exp_o = 1'b1;
        end
      end else if (exp_v && rdy) begin
        exp_v = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic d, input logic dv, input logic fl,
                      input logic rdy);
    reset = r; din = d; din_valid = dv; flush = fl; dout_ready = rdy;
    @(posedge clk);
    model_edge(r, d, dv, fl, rdy);
    #1;
    chk("dout_m",      32'(bus_m.dout),       32'(exp_m));
    chk("dout_l",      32'(bus_l.dout),       32'(exp_l));
    chk("valid_m",     32'(bus_m.dout_valid), 32'(exp_v));
    chk("valid_l",     32'(bus_l.dout_valid), 32'(exp_v));
    chk("bit_count_m", 32'(bus_m.bit_count),  32'(q.size()));
    chk("bit_count_l", 32'(bus_l.bit_count),  32'(q.size()));
    chk("overflow_m",  32'(bus_m.overflow),   32'(exp_o));
    chk("overflow_l",  32'(bus_l.overflow),   32'(exp_o));
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_rest, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--)
      step(1'b0, w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_rest);
  endtask

  initial begin
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    logic [W-1:0] bits_c1;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_dout", 32'(bus_m.dout), 32'h0);

    // Case 1/2: stream 1,0,1,1,0,0,1,0 with ready high
    bits_c1 = 8'b1011_0010;
    send_word(bits_c1, 1'b1, 1'b1);
    chk("c1_dout_msb", 32'(bus_m.dout), 32'hB2);
    chk("c2_dout_lsb", 32'(bus_l.dout), 32'h4D);
    chk("c1_valid", 32'(bus_m.dout_valid), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("c1_valid_drop", 32'(bus_m.dout_valid), 32'h0);

    // Case 3: two words into a stalled output
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("c3_dout_held", 32'(bus_m.dout), 32'hA5);
    chk("c3_overflow", 32'(bus_m.overflow), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("c3_valid_cleared", 32'(bus_m.dout_valid), 32'h0);

    // Case 6: reset with partial word, valid and overflow all set
    send_word(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("c6_pre_count", 32'(bus_m.bit_count), 32'h6);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("c6_valid_zero", 32'(bus_m.dout_valid), 32'h0);
    chk("c6_overflow_zero", 32'(bus_m.overflow), 32'h0);

    // Case 4: continuous stream, ready only on the edge completing word 2
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    send_word(w1, 1'b0, 1'b0);
    chk("c4_word1", 32'(bus_m.dout), 32'(w1));
    send_word(w2, 1'b0, 1'b1);
    chk("c4_word2", 32'(bus_m.dout), 32'(w2));
    chk("c4_valid_kept", 32'(bus_m.dout_valid), 32'h1);
    chk("c4_no_overflow", 32'(bus_m.overflow), 32'h0);

    // Case 5: partial word, flush while valid, then 8'hFF
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("c5_flush_dout", 32'(bus_m.dout), 32'(w2));
    chk("c5_flush_count", 32'(bus_m.bit_count), 32'h0);
    send_word(8'hFF, 1'b0, 1'b1);
    chk("c5_dout_ff", 32'(bus_m.dout), 32'hFF);
    chk("c5_count_zero", 32'(bus_m.bit_count), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("c5_flush_handshake", 32'(bus_m.dout_valid), 32'h0);

    // din_valid gaps of 1-3 cycles inside a word, with din toggling during gaps
    for (int k = 0; k < 4; k++) begin
      w1 = 8'($urandom);
      for (int i = W - 1; i >= 0; i--) begin
        step(1'b0, w1[i], 1'b1, 1'b0, 1'b1);
        if (i > 0)
          repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end
      chk("gap_word", 32'(bus_m.dout), 32'(w1));
    end

    // Random traffic including occasional flush and reset
    for (int n = 0; n < 600; n++)
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 2) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in dout[WIDTH-1], 0 = first received bit lands in dout[0].
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port din  input  1  serial data bit, normally the q of the upstream D flip-flop stage.
REQ-006 Port din_valid  input  1  qualifies din; a bit is consumed only on a rising clk edge with din_valid=1.
REQ-007 Port flush  input  1  synchronous abort of the partially assembled word.
REQ-008 Port dout  output  WIDTH  assembled parallel word, registered.
REQ-009 Port dout_valid  output  1  dout holds an unconsumed word.
REQ-010 Port dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
REQ-011 Port bit_count  output  clog2(WIDTH+1)  number of bits currently held in the shift register.
REQ-012 Port overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 The block SHALL contain a WIDTH-bit shift register, a bit counter, and a WIDTH-bit output holding register; all outputs SHALL be registered.
REQ-014 The bit counter SHALL increment by 1 on each consumed bit; it SHALL return to 0 on the edge that consumes bit WIDTH; it SHALL never read WIDTH.
REQ-015 With MSB_FIRST=1, each consumed bit SHALL shift in at bit 0 with existing bits moving toward the MSB; with MSB_FIRST=0, each bit SHALL shift in at bit WIDTH-1 with existing bits moving toward the LSB.
REQ-016 On the edge consuming the WIDTH-th bit, the completed word, including that bit, SHALL be written to dout and dout_valid SHALL be set, giving 1-cycle latency from the last bit to dout_valid.
REQ-017 The output register SHALL be able to load on that edge if dout_valid=0, or if dout_valid=1 and dout_ready=1.
REQ-018 If the output register loads while a handshake also occurs on the same edge, dout SHALL take the new word and dout_valid SHALL remain 1.
REQ-019 A handshake with no word completing SHALL clear dout_valid on that edge; dout SHALL keep its last value.
REQ-020 If a word completes while dout_valid=1 and dout_ready=0, the new word SHALL be discarded, dout and dout_valid SHALL be unchanged, and overflow SHALL be set.
REQ-021 Once set, overflow SHALL stay 1 until reset.
REQ-022 din and din_valid SHALL be accepted every cycle; there is no backpressure toward the serial side.
REQ-023 flush=1 SHALL zero bit_count and the shift register on that edge and SHALL discard any din_valid bit on that edge.
REQ-024 flush SHALL NOT affect dout, dout_valid or overflow; a dout handshake on a flush edge SHALL still complete.
REQ-025 din_valid=0 SHALL hold the shift register and bit_count.
REQ-026 dout, dout_valid and bit_count SHALL NOT change due to din while din_valid=0 and flush=0.

Reset
REQ-027 On an edge with reset=1, the block SHALL set shift register = 0, bit_count = 0, dout = 0, dout_valid = 0 and overflow = 0.
REQ-028 Reset SHALL take priority over flush, din_valid and dout_ready.
REQ-029 A partial word in progress at reset SHALL be lost.
REQ-030 The first bit consumed after reset deasserts SHALL be bit 0 of a new word.

Verification
REQ-031 Case 1: WIDTH=8, MSB_FIRST=1, dout_ready=1, serial bits 1,0,1,1,0,0,1,0 on consecutive cycles -> dout=8'hB2 and dout_valid=1 the cycle after the 8th bit, dout_valid=0 one cycle later.
REQ-032 Case 2: MSB_FIRST=0 with the same bit stream -> dout=8'h4D.
REQ-033 Case 3: dout_ready=0, two back-to-back words 8'hA5 then 8'h3C -> dout stays 8'hA5 and overflow=1 after the 16th bit; after a 1-cycle dout_ready pulse, dout_valid=0.
REQ-034 Case 4: continuous stream with dout_ready=1 only on the edge completing the 2nd word -> dout_valid stays 1 and dout changes directly from word 1 to word 2.
REQ-035 Case 5: 5 bits sent, then flush, then 8 bits 8'hFF -> dout=8'hFF and bit_count=0 afterward; flush with dout_valid=1 leaves dout unchanged.
REQ-036 Case 6: reset asserted with bit_count=6, dout_valid=1 and overflow=1 -> all outputs 0 on the next edge; din_valid gaps of 1-3 cycles inside a word do not change the assembled value.
